mul_hilo_seq: RTL
=================

# mul_hilo_seq

Sequencer and HI/LO result register for the CPU's multiply path. Accepts a multiply request from the execute stage and latches the operands. Drives the shift-add multiplier (one-cycle `St` pulse, operands held stable), waits its fixed latency, then captures the 2*WIDTH-bit product into HI/LO. Adds signed-multiply support around the unsigned multiplier by sign-magnitude conversion, and stalls the pipeline while busy.

## Interface
- `WIDTH`, 16, operand width; product and HI:LO are 2*WIDTH.
- `MUL_CYCLES`, 33, multiplier cycles from the edge sampling `St` until `Produto` is final.
- `Clk` input 1: single clock, all state on rising edge.
- `Reset` input 1: asynchronous, active-low (0 = reset).
- `Mul_Start` input 1: multiply request, sampled on rising edge.
- `Signed` input 1: operands are two's complement when 1, unsigned when 0; sampled with `Mul_Start`.
- `A`, `B` input WIDTH: operands, sampled with `Mul_Start`.
- `Hi_We`, `Lo_We` input 1: direct writes (MTHI/MTLO).
- `Wdata` input WIDTH: data for `Hi_We`/`Lo_We`.
- `Produto` input 2*WIDTH: product from the multiplier.
- `St` output 1: start pulse to the multiplier.
- `Multiplicando`, `Multiplicador` output WIDTH: operand magnitudes to the multiplier, held constant for the whole operation.
- `Busy` output 1: pipeline stall request.
- `Done` output 1: one-cycle completion pulse.
- `Hi`, `Lo` output WIDTH: upper and lower halves of the result register.

## Operation
- States: IDLE, START, WAIT, DONE. All outputs are registered.
- Reset values: state IDLE, counter 0; `St`, `Busy`, `Done` = 0; `Hi`, `Lo`, `Multiplicando`, `Multiplicador` = 0; internal sign flag = 0.
- IDLE or DONE with `Mul_Start`=1 goes to START and latches the operands:
  - `Multiplicando` = |A|, `Multiplicador` = |B|. Magnitude is the two's-complement negate when `Signed`=1 and msb=1; otherwise the raw value.
  - Sign flag = `Signed` & (A[msb] ^ B[msb]).
  - Most-negative operand (0x8000 at WIDTH=16) maps to magnitude 0x8000 as unsigned; no overflow.
- DONE with `Mul_Start`=0 goes to IDLE.
- START, exactly 1 cycle: `St`=1, `Busy`=1. Counter loads MUL_CYCLES-1. Next state WAIT.
- WAIT: `Busy`=1, `St`=0; counter decrements each cycle. On the edge where counter==0, go to DONE and capture the product:
  - {Hi,Lo} = sign flag ? (~Produto + 1) mod 2^(2*WIDTH) : Produto.
- DONE, 1 cycle: `Done`=1, `Busy`=0.
- `Mul_Start` in START or WAIT is ignored; no queuing.
- `Hi_We`/`Lo_We` take effect only when not `Busy` (IDLE or DONE). Each writes `Wdata` into `Hi`/`Lo`; both may be asserted together. Ignored while `Busy`.
- `Hi_We`/`Lo_We` together with `Mul_Start` (both accepted): the write lands now, and the multiply result later overwrites both halves.
- The capture edge has priority over any direct write; direct writes cannot occur in WAIT anyway.
- `Multiplicando`/`Multiplicador` change only on an accepted `Mul_Start`.

## Timing
- `Mul_Start` sampled at edge E0:
  - `St` high during cycle E0..E1.
  - WAIT occupies MUL_CYCLES cycles, E1..E(1+MUL_CYCLES).
  - `Hi`/`Lo` valid after edge E(1+MUL_CYCLES).
  - `Done` high during cycle E(1+MUL_CYCLES)..E(2+MUL_CYCLES).
- Default parameters: `Hi`/`Lo` update at E34, `Done` at E34..E35.
- `Busy` is high from E0 to E(1+MUL_CYCLES): exactly MUL_CYCLES+1 cycles.
- Back-to-back: `Mul_Start` held high through DONE re-enters START at the next edge. Throughput is one multiply per MUL_CYCLES+2 cycles.
- `Reset` asserted mid-operation: immediately (asynchronously) returns to IDLE and clears every output, including `Hi`/`Lo`. No partial result is written. After release, the next `Mul_Start` starts a clean operation.
- `Hi`/`Lo` reads are combinational from registers: zero latency, stable while `Busy`.

## Test plan
- Reset: hold `Reset`=0 and clock 5 cycles -> all outputs 0, `Busy`=0. Release, then `Mul_Start` with A=3, B=5, Signed=0 -> `St` for one cycle; after E34: Hi=0x0000, Lo=0x000F; `Done` pulses once.
- Unsigned max: A=B=0xFFFF, Signed=0 -> {Hi,Lo}=0xFFFE0001. `Busy` high exactly 34 cycles; `Multiplicando`=`Multiplicador`=0xFFFF throughout.
- Signed, single negative operand: A=0xFFFD (-3), B=7, Signed=1 -> magnitudes 3 and 7; {Hi,Lo}=0xFFFFFFEB.
- Signed, both most-negative: A=B=0x8000, Signed=1 -> {Hi,Lo}=0x40000000. Same operands with Signed=0 -> 0x40000000.
- Ignored writes and requests: `Hi_We`=1 with Wdata=0x1234 during WAIT, plus a second `Mul_Start` during WAIT -> both ignored; final result equals the first multiply; no second `St`.
- Reset mid-WAIT: assert `Reset` at cycle 10 of WAIT -> `Busy`, `St` = 0 immediately; `Hi`=`Lo`=0; no `Done`. Then MTLO `Wdata`=0xBEEF with `Lo_We`=1 in IDLE -> `Lo`=0xBEEF next cycle.

Source files
------------

// File: rtl/mul_hilo_seq.sv
// Multiply sequencer with HI/LO result register: drives an external unsigned
// shift-add multiplier and wraps it with sign-magnitude handling for signed ops.
module mul_hilo_seq #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 33
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Mul_Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 Hi_We,
    input  logic                 Lo_We,
    input  logic [WIDTH-1:0]     Wdata,
    input  logic [2*WIDTH-1:0]   Produto,
    output logic                 St,
    output logic [WIDTH-1:0]     Multiplicando,
    output logic [WIDTH-1:0]     Multiplicador,
    output logic                 Busy,
    output logic                 Done,
    output logic [WIDTH-1:0]     Hi,
    output logic [WIDTH-1:0]     Lo
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             neg_result;
    logic             idle_like;
    logic             accept;
    logic             capture;

    // The most-negative operand negates to itself, which is exactly its
    // unsigned magnitude, so no extra overflow handling is needed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic            is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p,
                                                 input logic          neg);
        return neg ? (~p + PW'(1)) : p;
    endfunction

    always_comb begin
        idle_like  = (state == S_IDLE) || (state == S_DONE);
        accept     = idle_like && Mul_Start;
        capture    = (state == S_WAIT) && (cnt == '0);
        state_next = state;
        unique case (state)
            S_IDLE:  if (Mul_Start) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (cnt == '0) state_next = S_DONE;
            S_DONE:  state_next = Mul_Start ? S_START : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            St    <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            St    <= (state_next == S_START);
            Busy  <= (state_next == S_START) || (state_next == S_WAIT);
            Done  <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (state == S_START) begin
            cnt <= CNT_LOAD;
        end else if ((state == S_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Multiplicando <= '0;
            Multiplicador <= '0;
            neg_result    <= 1'b0;
        end else if (accept) begin
            Multiplicando <= magnitude(A, Signed);
            Multiplicador <= magnitude(B, Signed);
            neg_result    <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        end
    end

    // Product capture and direct writes never coincide: writes are only
    // honoured outside START/WAIT, capture only happens in WAIT.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Hi <= '0;
            Lo <= '0;
        end else if (capture) begin
            {Hi, Lo} <= apply_sign(Produto, neg_result);
        end else if (idle_like) begin
            if (Hi_We) Hi <= Wdata;
            if (Lo_We) Lo <= Wdata;
        end
    end

endmodule
